// File: rtl/reset_request_gen_pkg.sv
// Shared definitions for the reset request generator: FSM encoding, cause bit
// indices and the ns-per-us constant used by the time base.
package reset_request_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam int unsigned CAUSE_SW  = 0;
  localparam int unsigned CAUSE_WDT = 1;
  localparam int unsigned CAUSE_PLL = 2;

  localparam int unsigned NS_PER_US = 1000;

endpackage

// File: rtl/reset_request_gen_us_timebase.sv
// Microsecond tick generator: accumulates COUNT_UNIT_NS per cycle and emits a
// one-cycle tick every whole microsecond. clr_i restarts the phase.
module us_timebase #(
  parameter int unsigned COUNT_UNIT_NS = 10
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  output logic tick_o
);
  import reset_request_gen_pkg::*;

  localparam int unsigned CNT_W = $clog2(NS_PER_US);
  localparam logic [CNT_W-1:0] STEP_NS = CNT_W'(COUNT_UNIT_NS);
  localparam logic [CNT_W-1:0] LAST_NS = CNT_W'(NS_PER_US - COUNT_UNIT_NS);

  logic [CNT_W-1:0] cnt_ns;

  assign tick_o = (cnt_ns >= LAST_NS);

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i || tick_o) begin
      cnt_ns <= '0;
    end else begin
      cnt_ns <= cnt_ns + STEP_NS;
    end
  end

endmodule

// File: rtl/reset_request_gen.sv
// Reset request generator: merges sw strobe, watchdog and PLL lock loss into a
// stretched active-low request. PLL monitor built only with RST_REQ_PLL_MON_EN.
module reset_request_gen #(
  parameter int unsigned COUNT_UNIT_NS   = 10,
  parameter int unsigned WDT_TIMEOUT_US  = 1000,
  parameter int unsigned PULSE_US        = 5,
  parameter int unsigned HOLDOFF_US      = 20,
  parameter int unsigned LOCK_FILTER_CYC = 4
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_en_i,
  input  logic       wdt_kick_i,
  input  logic       pll_lock_i,
  output logic       rst_req_n_o,
  output logic       rst_busy_o,
  output logic [2:0] rst_cause_o
);
  import reset_request_gen_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] ph_us_q, ph_us_d;
  logic        us_tick;
  logic        state_entry;
  logic        enter_assert;
  logic [31:0] wdt_us;
  logic        wdt_trig;
  logic        pll_trig;
  logic        trig;

  // Phase restarts on every state change so timed states span whole us
  us_timebase #(
    .COUNT_UNIT_NS(COUNT_UNIT_NS)
  ) u_us_timebase (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .clr_i (state_entry),
    .tick_o(us_tick)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wdt_us <= '0;
    end else if ((state_q != ST_IDLE) || !wdt_en_i || wdt_kick_i) begin
      wdt_us <= '0;
    end else if (us_tick) begin
      wdt_us <= wdt_us + 32'd1;
    end
  end

  assign wdt_trig = (wdt_us >= WDT_TIMEOUT_US);

`ifdef RST_REQ_PLL_MON_EN
  logic        pll_armed;
  logic [31:0] low_cnt;

  // Disarm on every request so a dead PLL cannot loop resets
  always_ff @(posedge clk_i) begin
    if (srst_i || enter_assert) begin
      pll_armed <= 1'b0;
      low_cnt   <= '0;
    end else if (pll_lock_i) begin
      pll_armed <= 1'b1;
      low_cnt   <= '0;
    end else if (pll_armed && (low_cnt < LOCK_FILTER_CYC)) begin
      low_cnt <= low_cnt + 32'd1;
    end
  end

  assign pll_trig = pll_armed && (low_cnt >= LOCK_FILTER_CYC);
`else
  logic unused_pll_lock;
  assign unused_pll_lock = pll_lock_i;
  assign pll_trig        = 1'b0;
`endif

  assign trig         = sw_rst_req_i | wdt_trig | pll_trig;
  assign enter_assert = (state_q == ST_IDLE) && trig;
  assign state_entry  = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    ph_us_d = ph_us_q;
    case (state_q)
      ST_IDLE: begin
        ph_us_d = '0;
        if (trig) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (us_tick) begin
          if (ph_us_q == PULSE_US - 1) begin
            state_d = ST_HOLDOFF;
            ph_us_d = '0;
          end else begin
            ph_us_d = ph_us_q + 32'd1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (us_tick) begin
          if (ph_us_q == HOLDOFF_US - 1) begin
            state_d = ST_IDLE;
            ph_us_d = '0;
          end else begin
            ph_us_d = ph_us_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_us_d = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they change on the entry edge
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      ph_us_q     <= '0;
      rst_req_n_o <= 1'b1;
      rst_busy_o  <= 1'b0;
      rst_cause_o <= '0;
    end else begin
      state_q     <= state_d;
      ph_us_q     <= ph_us_d;
      rst_req_n_o <= (state_d != ST_ASSERT);
      rst_busy_o  <= (state_d != ST_IDLE);
      if (enter_assert) begin
        rst_cause_o[CAUSE_SW]  <= sw_rst_req_i;
        rst_cause_o[CAUSE_WDT] <= wdt_trig;
        rst_cause_o[CAUSE_PLL] <= pll_trig;
      end
    end
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Randomized bench for reset_request_gen against a timestamp-based reference
// model of request windows, us phase, watchdog and PLL lock-loss rules.
module tb_reset_request_gen;

  localparam int CU     = 100;
  localparam int WDT_US = 5;
  localparam int P_US   = 2;
  localparam int H_US   = 3;
  localparam int LF     = 4;
  localparam int CPU    = 1000 / CU;
  localparam int P_CYC  = P_US * CPU;
  localparam int H_CYC  = H_US * CPU;
  localparam int NEVER  = -1000000;
`ifdef RST_REQ_PLL_MON_EN
  localparam bit PLL_EN = 1'b1;
`else
  localparam bit PLL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       srst, sw, wen, kick, lock;
  logic       req_n, busy;
  logic [2:0] cause;

  reset_request_gen #(
    .COUNT_UNIT_NS  (CU),
    .WDT_TIMEOUT_US (WDT_US),
    .PULSE_US       (P_US),
    .HOLDOFF_US     (H_US),
    .LOCK_FILTER_CYC(LF)
  ) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .sw_rst_req_i(sw),
    .wdt_en_i    (wen),
    .wdt_kick_i  (kick),
    .pll_lock_i  (lock),
    .rst_req_n_o (req_n),
    .rst_busy_o  (busy),
    .rst_cause_o (cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: request start edge, last phase-restart edge, counters
  int         edge_n = 0;
  int         start  = NEVER;
  int         lc     = 0;
  int         wcnt   = 0;
  int         lowrun = 0;
  bit         armed  = 1'b0;
  logic [2:0] mcause = 3'b000;

  int   dut_falls = 0, dut_low = 0, dut_busy = 0;
  logic prev_req_n = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic step();
    int e, d;
    bit pre_idle, tick, wtrig, ptrig, trig;
    e        = edge_n + 1;
    pre_idle = (e - 1 - start) >= (P_CYC + H_CYC);
    tick     = ((e - 1 - lc) % CPU) == (CPU - 1);
    wtrig    = (wcnt >= WDT_US);
    ptrig    = PLL_EN && armed && (lowrun >= LF);
    trig     = pre_idle && (sw || wtrig || ptrig);
    @(posedge clk);
    #1;
    edge_n = e;
    if (srst) begin
      start = NEVER; lc = e; wcnt = 0; armed = 1'b0; lowrun = 0; mcause = 3'b000;
    end else begin
      if (!pre_idle || !wen || kick) wcnt = 0;
      else if (tick) wcnt++;
      if (trig) begin
        armed = 1'b0; lowrun = 0;
      end else if (lock) begin
        armed = 1'b1; lowrun = 0;
      end else if (armed) begin
        lowrun++;
      end
      if (trig) begin
        start  = e;
        lc     = e;
        mcause = {ptrig, wtrig, sw};
      end else if ((e - start) == P_CYC || (e - start) == (P_CYC + H_CYC)) begin
        lc = e;
      end
    end
    d = e - start;
    check_eq("req_n", 32'(req_n), (d >= 0 && d < P_CYC) ? 32'd0 : 32'd1);
    check_eq("busy", 32'(busy), (d >= 0 && d < P_CYC + H_CYC) ? 32'd1 : 32'd0);
    check_eq("cause", 32'(cause), 32'(mcause));
    if (prev_req_n === 1'b1 && req_n === 1'b0) dut_falls++;
    if (req_n === 1'b0) dut_low++;
    if (busy === 1'b1) dut_busy++;
    prev_req_n = req_n;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int f0, l0, b0, gap;
    bit found;
    srst = 1'b1; sw = 1'b0; wen = 1'b0; kick = 1'b0; lock = 1'b0;
    run(3);
    check_eq("rst_req_n", 32'(req_n), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cause", 32'(cause), 32'd0);
    srst = 1'b0; lock = 1'b1;
    run(47);

    // software strobe
    f0 = dut_falls; l0 = dut_low; b0 = dut_busy;
    run($urandom_range(0, 20));
    sw = 1'b1; step(); sw = 1'b0;
    run(P_CYC + H_CYC + 5);
    check_eq("sw_falls", 32'(dut_falls - f0), 32'd1);
    check_eq("sw_low_cycles", 32'(dut_low - l0), 32'(P_CYC));
    check_eq("sw_busy_cycles", 32'(dut_busy - b0), 32'(P_CYC + H_CYC));
    check_eq("sw_cause", 32'(cause), 32'd1);

    // watchdog expiry, then kicked watchdog
    f0 = dut_falls;
    wen = 1'b1; run(60);
    check_eq("wdt_falls", 32'(dut_falls - f0), 32'd1);
    check_eq("wdt_cause", 32'(cause), 32'd2);
    wen = 1'b0; run(60);
    f0 = dut_falls; wen = 1'b1; gap = 0;
    for (int i = 0; i < 1000; i++) begin
      if (gap == 0) begin
        kick = 1'b1; gap = $urandom_range(10, 29);
      end else begin
        kick = 1'b0; gap--;
      end
      step();
    end
    kick = 1'b0; wen = 1'b0;
    check_eq("wdt_kicked_falls", 32'(dut_falls - f0), 32'd0);
    run(5);

    // PLL lock loss: short glitch, then persistent loss
    f0 = dut_falls;
    lock = 1'b1; run(5);
    lock = 1'b0; run(LF - 1);
    lock = 1'b1; run(10);
    check_eq("pll_glitch_falls", 32'(dut_falls - f0), 32'd0);
    lock = 1'b0; run(150);
    check_eq("pll_loss_falls", 32'(dut_falls - f0), PLL_EN ? 32'd1 : 32'd0);
    check_eq("pll_cause_bit", 32'(cause[2]), PLL_EN ? 32'd1 : 32'd0);
    lock = 1'b1; run(10);

    // sw strobe coincident with watchdog expiry; sw strobe during holdoff
    f0 = dut_falls; found = 1'b0; wen = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      sw = (wcnt >= WDT_US);
      step();
      if (sw) found = 1'b1;
    end
    sw = 1'b0; wen = 1'b0;
    check_eq("coinc_found", 32'(found), 32'd1);
    check_eq("coinc_cause", 32'(cause), 32'd3);
    run(P_CYC + 5);
    sw = 1'b1; step(); sw = 1'b0;
    run(H_CYC + 10);
    check_eq("holdoff_falls", 32'(dut_falls - f0), 32'd1);

    // srst in the middle of the pulse
    sw = 1'b1; step(); sw = 1'b0;
    run(4);
    check_eq("mid_req_low", 32'(req_n), 32'd0);
    srst = 1'b1; step(); srst = 1'b0;
    check_eq("mid_srst_req_n", 32'(req_n), 32'd1);
    check_eq("mid_srst_busy", 32'(busy), 32'd0);
    check_eq("mid_srst_cause", 32'(cause), 32'd0);
    run(5);

    // random mix of all inputs
    for (int i = 0; i < 3000; i++) begin
      sw   = ($urandom_range(0, 149) == 0);
      kick = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) wen = ~wen;
      if ($urandom_range(0, 9) == 0) lock = ~lock;
      srst = ($urandom_range(0, 799) == 0);
      step();
    end
    srst = 1'b0; sw = 1'b0; kick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_request_gen.md
# reset_request_gen

- Originates reset requests for the synchronous reset controller.
- Merges three sources into one stretched, active-low request pulse:
  - software reset strobe
  - watchdog timeout
  - PLL lock-loss monitor
- Must sit in the always-on domain, with a power-on-only reset. Its own reset must never be derived from the reset it requests.
- Reports the cause of the last request for post-reset diagnosis.

## Interface
- COUNT_UNIT_NS, 10: clock period in ns. Must divide 1000.
- WDT_TIMEOUT_US, 1000: watchdog timeout in µs.
- PULSE_US, 5: width of the request pulse in µs.
- HOLDOFF_US, 20: trigger-ignore window after the pulse ends, in µs.
- LOCK_FILTER_CYC, 4: number of consecutive low pll_lock_i samples that count as lock loss.
- clk_i  in  1  single clock.
- srst_i  in  1  synchronous, active-high reset (power-on domain only).
- sw_rst_req_i  in  1  software reset strobe, sampled every cycle.
- wdt_en_i  in  1  watchdog enable. While low, the watchdog counter is held at 0.
- wdt_kick_i  in  1  watchdog refresh. A 1-cycle pulse clears the counter.
- pll_lock_i  in  1  PLL lock, already synchronised to clk_i.
- rst_req_n_o  out  1  active-low reset request, registered. Drives the reset controller's async reset input.
- rst_busy_o  out  1  high in ASSERT and HOLDOFF.
- rst_cause_o  out  3  sticky cause bits: bit0 = sw, bit1 = wdt, bit2 = pll.

## Operation
- **Time base:** cnt_ns adds COUNT_UNIT_NS every cycle.
  - In a cycle where cnt_ns ≥ 1000−COUNT_UNIT_NS: us_tick = 1 and cnt_ns ← 0.
  - So 1 µs = 1000/COUNT_UNIT_NS cycles.
  - cnt_ns is cleared on every FSM state entry, so each timed phase spans exact whole µs.
- **Watchdog:** 32-bit wdt_us counter.
  - Increments on us_tick while wdt_en_i = 1 and the FSM is in IDLE.
  - Cleared by wdt_kick_i, by wdt_en_i = 0, or while not in IDLE. A kick takes priority over a tick in the same cycle.
  - wdt_trig = 1 when wdt_us ≥ WDT_TIMEOUT_US.
- **PLL monitor:**
  - The monitor arms after pll_lock_i has been seen high for one cycle.
  - While armed, a low counter counts consecutive low cycles; any high sample clears it.
  - pll_trig = 1 when the low count reaches LOCK_FILTER_CYC.
  - Entering ASSERT disarms the monitor. It re-arms only after lock is seen high again, so a PLL that stays dead cannot cause a reset loop.
- **FSM** (states IDLE, ASSERT, HOLDOFF):
  - IDLE: trig = sw_rst_req_i | wdt_trig | pll_trig. If trig, go to ASSERT and latch rst_cause_o ← {pll_trig, wdt_trig, sw_rst_req_i}. All simultaneous sources are recorded.
  - ASSERT: rst_req_n_o = 0. After PULSE_US µs ticks, go to HOLDOFF.
  - HOLDOFF: rst_req_n_o = 1. After HOLDOFF_US µs ticks, go to IDLE. All triggers arriving in ASSERT or HOLDOFF are dropped and not queued.
- rst_cause_o holds its value until the next entry to ASSERT or until srst_i.

## Timing
- **Values during/after srst_i:** rst_req_n_o = 1, rst_busy_o = 0, rst_cause_o = 0, FSM = IDLE, all counters 0, PLL monitor disarmed.
- **srst_i mid-pulse:** releases the request at the next edge (no pulse completion).
- **Latency:**
  - Trigger sampled at edge N: rst_req_n_o falls and rst_busy_o rises at edge N+1.
  - rst_req_n_o stays low for exactly PULSE_US·1000/COUNT_UNIT_NS cycles.
  - rst_busy_o falls exactly HOLDOFF_US·1000/COUNT_UNIT_NS cycles after rst_req_n_o rises.
- **Watchdog expiry:** trigger in the cycle after the WDT_TIMEOUT_US-th tick since the last kick, with a first-tick phase error under 1 µs.
- **Lock loss:** pll_trig in the cycle after the LOCK_FILTER_CYC-th consecutive low sample.

## Configuration
- **RST_REQ_PLL_MON_EN**
  - Defined: the PLL monitor is present as described above.
  - Undefined: the monitor logic is removed, pll_lock_i is ignored, pll_trig = 0, and rst_cause_o[2] is tied to 0. The port stays on the module.

## Structure
- **Shared package** holds:
  - FSM state encoding (IDLE = 2'd0, ASSERT = 2'd1, HOLDOFF = 2'd2)
  - cause bit indices (CAUSE_SW = 0, CAUSE_WDT = 1, CAUSE_PLL = 2)
  - NS_PER_US = 1000
- **Sub-module us_timebase:** the ns→µs tick generator with a synchronous clear input. It is reusable by other timed blocks.

## Test plan
Parameters for all scenarios: COUNT_UNIT_NS = 100 (10 cycles/µs), PULSE_US = 2, HOLDOFF_US = 3, WDT_TIMEOUT_US = 5, LOCK_FILTER_CYC = 4.
- sw_rst_req_i pulse at cycle 50 -> rst_req_n_o low on cycles 51–70 and rst_busy_o low again at cycle 101; rst_cause_o = 3'b001.
- wdt_en_i = 1, no kicks -> request about 50 cycles after enable; cause = 3'b010. With a kick every 30 cycles -> no request for 1000 cycles.
- pll_lock_i high, then low for 3 cycles, then high -> no request. Low for 4 cycles -> request; cause = 3'b100. Lock held low afterwards -> exactly one request.
- sw_rst_req_i and wdt expiry in the same cycle -> one pulse; cause = 3'b011. A sw_rst_req_i strobe during HOLDOFF -> ignored, no second pulse.
- srst_i asserted 5 cycles into ASSERT -> rst_req_n_o = 1 and cause = 0 at the next edge; FSM IDLE.
- Build without RST_REQ_PLL_MON_EN; toggle pll_lock_i low for 100 cycles -> no request; rst_cause_o[2] = 0.
